// File: rtl/adsr_envelope_pkg.sv
// Shared constants for the ADSR envelope / VCA voice stage.
// State encodings and default sample/envelope widths.
package adsr_envelope_pkg;

    localparam int VOLT_W_DEF = 12;
    localparam int ENV_W_DEF  = 12;

    typedef logic [VOLT_W_DEF-1:0] volt_t;
    typedef logic [ENV_W_DEF-1:0]  env_t;

    localparam logic [2:0] ENV_IDLE    = 3'd0;
    localparam logic [2:0] ENV_ATTACK  = 3'd1;
    localparam logic [2:0] ENV_DECAY   = 3'd2;
    localparam logic [2:0] ENV_SUSTAIN = 3'd3;
    localparam logic [2:0] ENV_RELEASE = 3'd4;

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/adsr_envelope_vca.sv
// Two-stage VCA: capture on dv rise, signed multiply, rebias to offset-binary.
// Strobe appears two clocks after the capture edge.
module env_vca
    import adsr_envelope_pkg::*;
#(
    parameter int VOLT_W = VOLT_W_DEF,
    parameter int ENV_W  = ENV_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VOLT_W-1:0] v_i,
    input  logic              dv_i,
    input  logic [ENV_W-1:0]  env_i,
    output logic [VOLT_W-1:0] vout_o,
    output logic              vout_dv_o
);

    localparam int PW = VOLT_W + ENV_W;
    localparam logic [VOLT_W-1:0] MID = {1'b1, {(VOLT_W-1){1'b0}}};

    logic              dv_q;
    logic              cap_q;
    logic [VOLT_W-1:0] v_q;
    logic [ENV_W-1:0]  e_q;
    logic              mul_q;
    logic [VOLT_W-1:0] hi_q;
    logic [VOLT_W-1:0] vout_q;
    logic              vout_dv_q;

    logic signed [VOLT_W-1:0] s;
    logic signed [PW-1:0]     s_x;
    logic signed [PW-1:0]     e_x;
    logic [VOLT_W-1:0]        prod_hi;
    logic [ENV_W-1:0]         unused_frac;
    logic                     cap;

    assign cap = dv_i & ~dv_q;
    // Flipping the MSB turns offset-binary into two's complement.
    assign s   = $signed({~v_q[VOLT_W-1], v_q[VOLT_W-2:0]});
    assign s_x = {{ENV_W{s[VOLT_W-1]}}, s};
    assign e_x = $signed({{VOLT_W{1'b0}}, e_q});
    assign {prod_hi, unused_frac} = s_x * e_x;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_q      <= 1'b0;
            cap_q     <= 1'b0;
            v_q       <= '0;
            e_q       <= '0;
            mul_q     <= 1'b0;
            hi_q      <= '0;
            vout_q    <= MID;
            vout_dv_q <= 1'b0;
        end else begin
            dv_q  <= dv_i;
            cap_q <= cap;
            if (cap) begin
                v_q <= v_i;
                e_q <= env_i;
            end
            mul_q <= cap_q;
            if (cap_q) hi_q <= prod_hi;
            vout_dv_q <= mul_q;
            if (mul_q) vout_q <= hi_q + MID;
        end
    end

    assign vout_o    = vout_q;
    assign vout_dv_o = vout_dv_q;

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope FSM with tick prescaler, feeding env_vca.
// Define ADSR_EXP_RELEASE_EN for exponential release.
module adsr_envelope
    import adsr_envelope_pkg::*;
#(
    parameter int VOLT_W        = VOLT_W_DEF,
    parameter int ENV_W         = ENV_W_DEF,
    parameter int TICK_DIV      = 4096,
    parameter int RELEASE_SHIFT = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              gate,
    input  logic [ENV_W-1:0]  attack_step,
    input  logic [ENV_W-1:0]  decay_step,
    input  logic [ENV_W-1:0]  release_step,
    input  logic [ENV_W-1:0]  sustain_level,
    input  logic [VOLT_W-1:0] v,
    input  logic              dv,
    output logic [VOLT_W-1:0] vout,
    output logic              vout_dv,
    output logic [ENV_W-1:0]  env,
    output logic              active
);

    localparam int CNT_W = cnt_width(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [ENV_W-1:0] ENV_MAX  = '1;

    logic [2:0]       state_q, state_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             gate_q;
    logic [ENV_W-1:0] att_q;
    logic [ENV_W-1:0] dec_q;
    logic [ENV_W-1:0] sus_q;
`ifndef ADSR_EXP_RELEASE_EN
    logic [ENV_W-1:0] rel_q;
`endif

    logic             rise;
    logic             fall;
    logic             tick;
    logic             held;
    logic [ENV_W:0]   att_sum;
    logic [ENV_W:0]   dec_floor;
    logic [ENV_W-1:0] rel_dec;

    assign rise      = gate & ~gate_q;
    assign fall      = ~gate & gate_q;
    assign tick      = (cnt_q == CNT_LAST);
    assign cnt_d     = tick ? '0 : cnt_q + 1'b1;
    assign att_sum   = {1'b0, env_q} + {1'b0, att_q};
    assign dec_floor = {1'b0, sus_q} + {1'b0, dec_q};
    assign held      = (state_q == ENV_ATTACK) |
                       (state_q == ENV_DECAY)  |
                       (state_q == ENV_SUSTAIN);

`ifdef ADSR_EXP_RELEASE_EN
    assign rel_dec = (env_q >> RELEASE_SHIFT) + ENV_W'(1);
`else
    assign rel_dec = rel_q;
`endif

    // Gate edges preempt tick arithmetic in the same cycle.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (rise) begin
            state_d = ENV_ATTACK;
        end else if (fall && held) begin
            state_d = ENV_RELEASE;
        end else if (tick) begin
            case (state_q)
                ENV_ATTACK: begin
                    if (att_q == '0 || att_sum >= {1'b0, ENV_MAX}) begin
                        env_d   = ENV_MAX;
                        state_d = ENV_DECAY;
                    end else begin
                        env_d = att_sum[ENV_W-1:0];
                    end
                end
                ENV_DECAY: begin
                    if (sus_q == ENV_MAX) begin
                        state_d = ENV_SUSTAIN;
                    end else if (dec_q == '0 || {1'b0, env_q} <= dec_floor) begin
                        env_d   = sus_q;
                        state_d = ENV_SUSTAIN;
                    end else begin
                        env_d = env_q - dec_q;
                    end
                end
                ENV_RELEASE: begin
                    if (rel_dec == '0 || env_q <= rel_dec) begin
                        env_d   = '0;
                        state_d = ENV_IDLE;
                    end else begin
                        env_d = env_q - rel_dec;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ENV_IDLE;
            env_q   <= '0;
            cnt_q   <= '0;
            gate_q  <= 1'b0;
            att_q   <= '0;
            dec_q   <= '0;
            sus_q   <= '0;
`ifndef ADSR_EXP_RELEASE_EN
            rel_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            cnt_q   <= cnt_d;
            gate_q  <= gate;
            if (rise) begin
                att_q <= attack_step;
                dec_q <= decay_step;
                sus_q <= sustain_level;
`ifndef ADSR_EXP_RELEASE_EN
                rel_q <= release_step;
`endif
            end
        end
    end

    env_vca #(
        .VOLT_W(VOLT_W),
        .ENV_W (ENV_W)
    ) u_vca (
        .clk      (clk),
        .rst      (rst),
        .v_i      (v),
        .dv_i     (dv),
        .env_i    (env_q),
        .vout_o   (vout),
        .vout_dv_o(vout_dv)
    );

    assign env    = env_q;
    assign active = (state_q != ENV_IDLE);

endmodule
